apb_initiator14: RTL
====================

// Module: apb_initiator14
// PURPOSE
//  APB3 initiator (master) that turns a simple request/response port into APB transfers.
//  Drives up to NUM_SLV APB peripherals of the apb_subsystem, e.g. the TTC and UART slaves.
//  Decodes the target slave from the upper request address bits and muxes its pready/prdata/pslverr.
//  Returns a status per transfer and enforces a pready timeout.
// PARAMETERS
//  NUM_SLV  4    number of APB slaves, psel14 width (1..16)
//  PADDR_W  8    APB address width driven on paddr14
//  TIMEOUT  255  ACCESS wait cycles before abort; 0 disables the timeout
// PORTS
//  pclk14         in   1              system clock
//  n_p_reset14    in   1              asynchronous active-low reset
//  req_valid14    in   1              request present
//  req_ready14    out  1              initiator can accept a request
//  req_write14    in   1              1 = write, 0 = read
//  req_addr14     in   PADDR_W+4      [PADDR_W+3:PADDR_W] = slave index, low bits = paddr
//  req_wdata14    in   32             write data
//  rsp_valid14    out  1              single-cycle response strobe
//  rsp_rdata14    out  32             read data; 0 for writes and for errors
//  rsp_status14   out  2              00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT
//  psel14         out  NUM_SLV        one-hot slave select
//  penable14      out  1              APB enable
//  pwrite14       out  1              APB direction
//  paddr14        out  PADDR_W        APB address
//  pwdata14       out  32             APB write data
//  prdata14       in   32*NUM_SLV     slave read data, slave i at [32*i+31:32*i]
//  pready14       in   NUM_SLV        per-slave ready
//  pslverr14      in   NUM_SLV        per-slave error
// BEHAVIOUR
//  Reset: every output is 0, except req_ready14=1. The state is IDLE.
//  Reset is asynchronous. If it asserts mid-transfer, the transfer is abandoned and no rsp_valid14 is produced.
//  FSM states and transitions:
//   IDLE: req_ready14=1. On req_valid14, latch write/addr/wdata/index.
//     index < NUM_SLV: go to SETUP.
//     index >= NUM_SLV: go to RESP with DECERR. No psel14 is driven.
//   SETUP: psel14[idx]=1, penable14=0. Always go to ACCESS after 1 cycle.
//   ACCESS: psel14[idx]=1, penable14=1. pready14/pslverr14/prdata14 are sampled only from the selected slave.
//     pready14=1: latch rdata (reads only) and status (pslverr14 ? SLVERR : OK), then go to RESP.
//     pready14=0: increment the wait counter.
//       If TIMEOUT!=0 and the counter == TIMEOUT: go to RESP with TIMEOUT.
//       psel14/penable14 drop on the next cycle.
//   RESP: rsp_valid14=1 for exactly 1 cycle (no backpressure). Then go to IDLE. The wait counter is cleared.
//  req_ready14 = (state==IDLE). A req_valid14 in any other state is ignored and not queued.
//  Latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid14 N+3 when pready14=1 at once.
//   Each pready14 wait cycle adds 1 cycle. Back-to-back throughput is 1 transfer per 4 cycles.
//  paddr14/pwrite14/pwdata14 are stable from SETUP to end of ACCESS.
//   They hold their last value when idle; only psel14/penable14 return to 0.
//  rsp_rdata14 carries prdata only for a read with OK status; otherwise it is 0.
//   rsp_status14/rsp_rdata14 are valid only while rsp_valid14=1.
//  pready14/pslverr14 of unselected slaves, and all APB inputs outside ACCESS, are ignored.
//  Wait counter width: clog2(TIMEOUT+1), minimum 1 bit; it saturates and never wraps.
// STRUCTURE
//  Shared defines file apb_init_defs14.v holds:
//   - state encodings ST_IDLE/ST_SETUP/ST_ACCESS/ST_RESP
//   - status codes STS_OK/STS_SLVERR/STS_DECERR/STS_TIMEOUT
//  Sub-module apb_rsp_mux14 (combinational): selects pready/pslverr/prdata by latched index.
//  The top level holds the FSM, the request registers and the timeout counter.
// TESTING
//  T1 Write: req addr=0x1_24, wdata=0xDEADBEEF, slave1 pready=1.
//   -> psel14=4'b0010 for 2 cycles, paddr14=0x24, rsp_valid14 at N+3, status 00.
//  T2 Read with 3 wait states: slave2 returns prdata=0x12345678.
//   -> rsp at N+6, rsp_rdata14=0x12345678, status 00.
//  T3 Decode error: addr index=5 with NUM_SLV=4.
//   -> psel14 stays 0, rsp at N+1, status 10, rdata 0.
//  T4 pslverr14=1 with pready14=1 on a read.
//   -> status 01, rsp_rdata14=0. Timeout: TIMEOUT=4 with pready14 held low -> status 11, psel14 drops.
//  T5 Reset asserted during ACCESS.
//   -> all APB outputs 0 immediately, no rsp_valid14, req_ready14=1 after release.
//  T6 Back-to-back requests with req_valid14 held high.
//   -> second is accepted only when req_ready14=1. Rsp strobes are 4 cycles apart.
//   Check the APB protocol assertion: paddr14 stable while psel14=1.

Source files
------------

// File: rtl/apb_initiator14_pkg.sv
// Shared types and constants for the apb_initiator14 APB3 initiator.
package apb_initiator14_pkg;

  // Width of the slave-index field at the top of the request address.
  localparam int unsigned IdxW  = 4;
  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    StsOk      = 2'b00,
    StsSlverr  = 2'b01,
    StsDecerr  = 2'b10,
    StsTimeout = 2'b11
  } status_e;

  // Wait counter must hold the value TIMEOUT; never narrower than 1 bit.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_rsp_mux14.sv
// Combinational response mux: picks pready/pslverr/prdata of the latched slave index.
module apb_rsp_mux14
  import apb_initiator14_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4
) (
  input  logic [IdxW-1:0]          idx_i,
  input  logic [DataW*NUM_SLV-1:0] prdata_i,
  input  logic [NUM_SLV-1:0]       pready_i,
  input  logic [NUM_SLV-1:0]       pslverr_i,
  output logic                     ready_o,
  output logic                     slverr_o,
  output logic [DataW-1:0]         rdata_o
);

  // Only the indexed slave contributes; an out-of-range index yields all zeros.
  always_comb begin
    ready_o  = 1'b0;
    slverr_o = 1'b0;
    rdata_o  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_i == IdxW'(i)) begin
        ready_o  = pready_i[i];
        slverr_o = pslverr_i[i];
        rdata_o  = prdata_i[DataW*i +: DataW];
      end
    end
  end

endmodule

// File: rtl/apb_initiator14.sv
// APB3 initiator: converts a request/response port into APB transfers to NUM_SLV slaves,
// with address-based slave decode and an optional pready timeout.
module apb_initiator14
  import apb_initiator14_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned PADDR_W = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     pclk14,
  input  logic                     n_p_reset14,
  input  logic                     req_valid14,
  output logic                     req_ready14,
  input  logic                     req_write14,
  input  logic [PADDR_W+3:0]       req_addr14,
  input  logic [DataW-1:0]         req_wdata14,
  output logic                     rsp_valid14,
  output logic [DataW-1:0]         rsp_rdata14,
  output logic [1:0]               rsp_status14,
  output logic [NUM_SLV-1:0]       psel14,
  output logic                     penable14,
  output logic                     pwrite14,
  output logic [PADDR_W-1:0]       paddr14,
  output logic [DataW-1:0]         pwdata14,
  input  logic [DataW*NUM_SLV-1:0] prdata14,
  input  logic [NUM_SLV-1:0]       pready14,
  input  logic [NUM_SLV-1:0]       pslverr14
);

  localparam int unsigned AddrW = PADDR_W + IdxW;
  localparam int unsigned CntW  = cnt_width(TIMEOUT);
  localparam logic [IdxW:0] NumSlvC = (IdxW + 1)'(NUM_SLV);
  localparam logic [CntW-1:0] TimeoutC = CntW'(TIMEOUT);

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [DataW-1:0]  rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              write_q;
  logic [PADDR_W-1:0] addr_q;
  logic [DataW-1:0]  wdata_q;
  logic [IdxW-1:0]   idx_q;
  logic              req_load;

  logic              sel_ready;
  logic              sel_slverr;
  logic [DataW-1:0]  sel_rdata;

  apb_rsp_mux14 #(
    .NUM_SLV (NUM_SLV)
  ) u_rsp_mux (
    .idx_i     (idx_q),
    .prdata_i  (prdata14),
    .pready_i  (pready14),
    .pslverr_i (pslverr14),
    .ready_o   (sel_ready),
    .slverr_o  (sel_slverr),
    .rdata_o   (sel_rdata)
  );

  // Next-state, response status/data capture and wait-counter update.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    req_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid14) begin
          req_load = 1'b1;
          rdata_d  = '0;
          cnt_d    = '0;
          if ({1'b0, req_addr14[AddrW-1:PADDR_W]} >= NumSlvC) begin
            status_d = StsDecerr;
            state_d  = StResp;
          end else begin
            status_d = StsOk;
            state_d  = StSetup;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (sel_ready) begin
          status_d = sel_slverr ? StsSlverr : StsOk;
          rdata_d  = (!write_q && !sel_slverr) ? sel_rdata : '0;
          state_d  = StResp;
        end else begin
          // Saturating so a disabled timeout never wraps back to a match.
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CntW'(1);
          end
          if ((TIMEOUT != 0) && (cnt_d == TimeoutC)) begin
            status_d = StsTimeout;
            rdata_d  = '0;
            state_d  = StResp;
          end
        end
      end
      StResp: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state, status, read data and wait counter.
  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      state_q  <= StIdle;
      status_q <= StsOk;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // Request registers; they keep driving paddr/pwrite/pwdata while idle.
  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
    end else if (req_load) begin
      write_q <= req_write14;
      addr_q  <= req_addr14[PADDR_W-1:0];
      wdata_q <= req_wdata14;
      idx_q   <= req_addr14[AddrW-1:PADDR_W];
    end
  end

  // One-hot select for SETUP and ACCESS only.
  always_comb begin
    psel14 = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      psel14[i] = ((state_q == StSetup) || (state_q == StAccess)) && (idx_q == IdxW'(i));
    end
  end

  assign req_ready14  = (state_q == StIdle);
  assign rsp_valid14  = (state_q == StResp);
  assign rsp_status14 = rsp_valid14 ? status_q : StsOk;
  assign rsp_rdata14  = rsp_valid14 ? rdata_q : '0;
  assign penable14    = (state_q == StAccess);
  assign pwrite14     = write_q;
  assign paddr14      = addr_q;
  assign pwdata14     = wdata_q;

endmodule
